fast_dram_latency_shaper: RTL
=============================

# fast_dram_latency_shaper

AXI3 slave-to-master stage placed directly upstream of the fast DRAM simulation model. It buffers read and write address requests and releases each one only after a fixed, parameterised number of cycles. This gives the zero-latency SRAM-backed DRAM model DDR-like request latency without changing its internals. W, B and R channels pass straight through.

## Interface
Parameters:
- BW_ADDR, 32, address width
- BW_DATA, 128, data width
- BW_AXI_TID, 16, AXI ID width
- RD_LATENCY, 20, cycles from rx AR handshake to earliest sxarvalid; 0 is treated as 1
- WR_LATENCY, 10, same for AW
- DEPTH, 4, outstanding entries per address queue; power of two, 2..16

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- rxaw{id,addr,len,size,burst,valid,ready}  slave AW; widths per `ervp_axi_define.vh`, BW_ADDR, BW_AXI_TID
- rxw{id,data,strb,last,valid,ready}  slave W
- rxb{id,resp,valid,ready}  slave B
- rxar{id,addr,len,size,burst,valid,ready}  slave AR
- rxr{id,data,resp,last,valid,ready}  slave R
- sxaw*, sxw*, sxb*, sxar*, sxr*  mirrored master ports toward the DRAM model

## Operation
- Two identical address queues, AR and AW, each DEPTH entries. Each entry holds {id, addr, len, size, burst, cnt}.
- Push:
  - rxarready = !full.
  - On rxarvalid && rxarready, write the tail entry with cnt = max(RD_LATENCY,1) − 1.
- Countdown:
  - Every cycle, every occupied entry with cnt ≠ 0 decrements by 1.
  - cnt saturates at 0; it never wraps.
- Pop:
  - sxarvalid = !empty && head.cnt == 0.
  - sxar* fields come from the head entry.
  - On sxarvalid && sxarready, the head advances.
- Ordering:
  - Strict FIFO per queue. An entry whose cnt reaches 0 behind a stalled head waits.
  - There is no ordering between the AR and AW queues.
- The AW queue behaves identically, using WR_LATENCY.
- Simultaneous push and pop in one cycle: both take effect and the occupancy count is unchanged.
- Full: ready stays low until a pop. A pop in cycle N raises ready in cycle N+1. Ready is registered, with no combinational path from sx*ready to rx*ready.
- Pass-through channels:
  - W/B/R are wired combinationally in both directions.
  - W may reach the DRAM model before its AW. The downstream controller accepts this per AXI rules.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values: rxawready = rxarready = 1, sxawvalid = sxarvalid = 0, all queue pointers, counts and cnt fields 0.
- W/B/R outputs follow their inputs combinationally, including during reset.
- Latency: an AR accepted in cycle T gives sxarvalid high in cycle T+max(RD_LATENCY,1) at the earliest, provided the queue was otherwise empty. AW behaves the same with WR_LATENCY.
- Once asserted, sxarvalid/sxawvalid and their payload hold stable until the handshake (AXI rule).
- Throughput: one push and one pop per queue per cycle. Back-to-back requests accepted in T and T+1 are released in T+L and T+L+1.
- Reset asserted mid-operation: the queues are emptied immediately and pending entries are discarded. Upstream must not reset one side only.

## Configuration
- FAST_DRAM_LATENCY_SHAPER_STAT_EN defined:
  - Adds output ports stat_rd_count[31:0], stat_wr_count[31:0] and stat_stall_cycles[31:0].
  - stat_rd_count and stat_wr_count count pops.
  - stat_stall_cycles counts cycles where either rx*valid && !rx*ready.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package: address-entry struct typedef {id, addr, len, size, burst, cnt}, the cnt width constant (REQUIRED_BITWIDTH of max latency), and the stat counter width.
- One sub-module, fast_dram_latency_queue, parameterised by LATENCY and DEPTH. It is instantiated twice (AR, AW). The top adds only wiring and the optional stats.

## Test plan
- Single AR, addr 0x100, RD_LATENCY = 20, accepted at cycle 10 -> sxarvalid first high at cycle 30 with addr 0x100 and the same id; R data returns unchanged.
- Five back-to-back ARs with DEPTH = 4 and sxarready held low -> rxarready low after the 4th accept; the 5th is accepted one cycle after the first pop; release order is 0..4.
- Head stalled by sxarready = 0 for 50 cycles -> the following entries pop on consecutive cycles immediately after release, with no additional latency.
- RD_LATENCY = 0 -> release at T+1; WR_LATENCY = 10 write burst, len 3 -> sxawvalid at T+10; 4 W beats pass through; one B with matching id.
- rst pulsed with 3 entries queued -> sxarvalid low next cycle, rxarready = 1, and no stale request is released afterwards.
- With STAT_EN: 7 reads and 3 writes completed -> stat_rd_count = 7, stat_wr_count = 3.

Source files
------------

// File: rtl/fast_dram_latency_shaper_pkg.sv
// Shared types and constants for the fast DRAM latency shaper.
// Optional statistics are enabled with FAST_DRAM_LATENCY_SHAPER_STAT_EN.
package fast_dram_latency_shaper_pkg;

    localparam int unsigned AXI_LEN_W   = 4;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    // Largest supported latency sets the countdown field width
    localparam int unsigned MAX_LATENCY = 255;
    localparam int unsigned CNT_W       = $clog2(MAX_LATENCY + 1);
    localparam int unsigned STAT_W      = 32;

    typedef struct packed {
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } axi_attr_t;

    // Initial countdown value; a latency of zero behaves like one
    function automatic logic [CNT_W-1:0] init_cnt(input int unsigned latency);
        return (latency > 1) ? CNT_W'(latency - 1) : '0;
    endfunction

endpackage

// File: rtl/fast_dram_latency_queue.sv
// Address request FIFO that holds each entry for a fixed number of cycles
// before presenting it at the head.
module fast_dram_latency_queue
    import fast_dram_latency_shaper_pkg::*;
#(
    parameter int unsigned BW_ADDR    = 32,
    parameter int unsigned BW_AXI_TID = 16,
    parameter int unsigned LATENCY    = 20,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BW_AXI_TID-1:0] push_id,
    input  logic [BW_ADDR-1:0]    push_addr,
    input  axi_attr_t             push_attr,
    input  logic                  push_valid,
    output logic                  push_ready,
    output logic [BW_AXI_TID-1:0] pop_id,
    output logic [BW_ADDR-1:0]    pop_addr,
    output axi_attr_t             pop_attr,
    output logic                  pop_valid,
    input  logic                  pop_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = init_cnt(LATENCY);

    typedef struct packed {
        logic [BW_AXI_TID-1:0] id;
        logic [BW_ADDR-1:0]    addr;
        axi_attr_t             attr;
        logic [CNT_W-1:0]      cnt;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             push;
    logic             pop;

    assign head      = mem[rd_ptr];
    assign push      = push_valid && push_ready;
    assign pop       = pop_valid && pop_ready;
    assign pop_valid = (count != '0) && (head.cnt == '0);
    assign pop_id    = head.id;
    assign pop_addr  = head.addr;
    assign pop_attr  = head.attr;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (PTR_W+1)'(1);
            2'b01:   count_next = count - (PTR_W+1)'(1);
            default: count_next = count;
        endcase
    end

    // Free slots always hold cnt == 0, so every nonzero counter belongs to a live entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (mem[i].cnt != '0) begin
                    mem[i].cnt <= mem[i].cnt - CNT_W'(1);
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{id: push_id, addr: push_addr, attr: push_attr, cnt: CNT_INIT};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_next;
            push_ready <= (count_next != (PTR_W+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/fast_dram_latency_shaper.sv
// AXI3 stage adding fixed AR/AW latency in front of the fast DRAM model; W/B/R pass through.
// Define FAST_DRAM_LATENCY_SHAPER_STAT_EN to add pop and stall statistics ports.
module fast_dram_latency_shaper
    import fast_dram_latency_shaper_pkg::*;
#(
    parameter int unsigned BW_ADDR    = 32,
    parameter int unsigned BW_DATA    = 128,
    parameter int unsigned BW_AXI_TID = 16,
    parameter int unsigned RD_LATENCY = 20,
    parameter int unsigned WR_LATENCY = 10,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BW_AXI_TID-1:0]  rxawid,
    input  logic [BW_ADDR-1:0]     rxawaddr,
    input  logic [AXI_LEN_W-1:0]   rxawlen,
    input  logic [AXI_SIZE_W-1:0]  rxawsize,
    input  logic [AXI_BURST_W-1:0] rxawburst,
    input  logic                   rxawvalid,
    output logic                   rxawready,
    input  logic [BW_AXI_TID-1:0]  rxwid,
    input  logic [BW_DATA-1:0]     rxwdata,
    input  logic [BW_DATA/8-1:0]   rxwstrb,
    input  logic                   rxwlast,
    input  logic                   rxwvalid,
    output logic                   rxwready,
    output logic [BW_AXI_TID-1:0]  rxbid,
    output logic [AXI_RESP_W-1:0]  rxbresp,
    output logic                   rxbvalid,
    input  logic                   rxbready,
    input  logic [BW_AXI_TID-1:0]  rxarid,
    input  logic [BW_ADDR-1:0]     rxaraddr,
    input  logic [AXI_LEN_W-1:0]   rxarlen,
    input  logic [AXI_SIZE_W-1:0]  rxarsize,
    input  logic [AXI_BURST_W-1:0] rxarburst,
    input  logic                   rxarvalid,
    output logic                   rxarready,
    output logic [BW_AXI_TID-1:0]  rxrid,
    output logic [BW_DATA-1:0]     rxrdata,
    output logic [AXI_RESP_W-1:0]  rxrresp,
    output logic                   rxrlast,
    output logic                   rxrvalid,
    input  logic                   rxrready,
    output logic [BW_AXI_TID-1:0]  sxawid,
    output logic [BW_ADDR-1:0]     sxawaddr,
    output logic [AXI_LEN_W-1:0]   sxawlen,
    output logic [AXI_SIZE_W-1:0]  sxawsize,
    output logic [AXI_BURST_W-1:0] sxawburst,
    output logic                   sxawvalid,
    input  logic                   sxawready,
    output logic [BW_AXI_TID-1:0]  sxwid,
    output logic [BW_DATA-1:0]     sxwdata,
    output logic [BW_DATA/8-1:0]   sxwstrb,
    output logic                   sxwlast,
    output logic                   sxwvalid,
    input  logic                   sxwready,
    input  logic [BW_AXI_TID-1:0]  sxbid,
    input  logic [AXI_RESP_W-1:0]  sxbresp,
    input  logic                   sxbvalid,
    output logic                   sxbready,
    output logic [BW_AXI_TID-1:0]  sxarid,
    output logic [BW_ADDR-1:0]     sxaraddr,
    output logic [AXI_LEN_W-1:0]   sxarlen,
    output logic [AXI_SIZE_W-1:0]  sxarsize,
    output logic [AXI_BURST_W-1:0] sxarburst,
    output logic                   sxarvalid,
    input  logic                   sxarready,
    input  logic [BW_AXI_TID-1:0]  sxrid,
    input  logic [BW_DATA-1:0]     sxrdata,
    input  logic [AXI_RESP_W-1:0]  sxrresp,
    input  logic                   sxrlast,
    input  logic                   sxrvalid,
    output logic                   sxrready
`ifdef FAST_DRAM_LATENCY_SHAPER_STAT_EN
    ,
    output logic [STAT_W-1:0]      stat_rd_count,
    output logic [STAT_W-1:0]      stat_wr_count,
    output logic [STAT_W-1:0]      stat_stall_cycles
`endif
);

    axi_attr_t aw_attr_in;
    axi_attr_t aw_attr_out;
    axi_attr_t ar_attr_in;
    axi_attr_t ar_attr_out;

    assign aw_attr_in = '{len: rxawlen, size: rxawsize, burst: rxawburst};
    assign ar_attr_in = '{len: rxarlen, size: rxarsize, burst: rxarburst};
    assign sxawlen    = aw_attr_out.len;
    assign sxawsize   = aw_attr_out.size;
    assign sxawburst  = aw_attr_out.burst;
    assign sxarlen    = ar_attr_out.len;
    assign sxarsize   = ar_attr_out.size;
    assign sxarburst  = ar_attr_out.burst;

    fast_dram_latency_queue #(
        .BW_ADDR(BW_ADDR), .BW_AXI_TID(BW_AXI_TID), .LATENCY(WR_LATENCY), .DEPTH(DEPTH)
    ) u_aw_queue (
        .clk(clk), .rst(rst),
        .push_id(rxawid), .push_addr(rxawaddr), .push_attr(aw_attr_in),
        .push_valid(rxawvalid), .push_ready(rxawready),
        .pop_id(sxawid), .pop_addr(sxawaddr), .pop_attr(aw_attr_out),
        .pop_valid(sxawvalid), .pop_ready(sxawready)
    );

    fast_dram_latency_queue #(
        .BW_ADDR(BW_ADDR), .BW_AXI_TID(BW_AXI_TID), .LATENCY(RD_LATENCY), .DEPTH(DEPTH)
    ) u_ar_queue (
        .clk(clk), .rst(rst),
        .push_id(rxarid), .push_addr(rxaraddr), .push_attr(ar_attr_in),
        .push_valid(rxarvalid), .push_ready(rxarready),
        .pop_id(sxarid), .pop_addr(sxaraddr), .pop_attr(ar_attr_out),
        .pop_valid(sxarvalid), .pop_ready(sxarready)
    );

    // Data and response channels are not delayed
    assign sxwid    = rxwid;
    assign sxwdata  = rxwdata;
    assign sxwstrb  = rxwstrb;
    assign sxwlast  = rxwlast;
    assign sxwvalid = rxwvalid;
    assign rxwready = sxwready;
    assign rxbid    = sxbid;
    assign rxbresp  = sxbresp;
    assign rxbvalid = sxbvalid;
    assign sxbready = rxbready;
    assign rxrid    = sxrid;
    assign rxrdata  = sxrdata;
    assign rxrresp  = sxrresp;
    assign rxrlast  = sxrlast;
    assign rxrvalid = sxrvalid;
    assign sxrready = rxrready;

`ifdef FAST_DRAM_LATENCY_SHAPER_STAT_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Saturating pop and upstream-stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_count     <= '0;
            stat_wr_count     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (sxarvalid && sxarready && (stat_rd_count != STAT_MAX)) begin
                stat_rd_count <= stat_rd_count + STAT_W'(1);
            end
            if (sxawvalid && sxawready && (stat_wr_count != STAT_MAX)) begin
                stat_wr_count <= stat_wr_count + STAT_W'(1);
            end
            if (((rxarvalid && !rxarready) || (rxawvalid && !rxawready)) &&
                (stat_stall_cycles != STAT_MAX)) begin
                stat_stall_cycles <= stat_stall_cycles + STAT_W'(1);
            end
        end
    end
`endif

endmodule
